// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-block BIST controller.
// Optional feature macro: GATE_BIST_STOP_ON_FAIL_EN (used by gate_bist_ctrl).
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int LANE_AND    = 0;
    localparam int LANE_NAND   = 1;
    localparam int LANE_XOR    = 2;
    localparam int LANE_XNOR   = 3;
    localparam int NUM_VECTORS = 256;
    localparam int ERR_W       = 9;

    // Operand A for vector index cnt: low nibble of cnt, complement in the high nibble
    function automatic logic [7:0] vec_a(input logic [7:0] cnt);
        return {~cnt[3:0], cnt[3:0]};
    endfunction

    // Operand B for vector index cnt: high nibble of cnt, complement in the high nibble
    function automatic logic [7:0] vec_b(input logic [7:0] cnt);
        return {~cnt[7:4], cnt[7:4]};
    endfunction

endpackage

// File: rtl/gate_bist_expect.sv
// Golden model of the 4-lane gate block: AND, NAND, XOR, XNOR on bits 3:0, upper bits 0.
module gate_bist_expect
    import gate_bist_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] exp
);

    // Per-lane expected result; unused lanes read as zero
    always_comb begin
        exp            = 8'h00;
        exp[LANE_AND]  = a[LANE_AND] & b[LANE_AND];
        exp[LANE_NAND] = ~(a[LANE_NAND] & b[LANE_NAND]);
        exp[LANE_XOR]  = a[LANE_XOR] ^ b[LANE_XOR];
        exp[LANE_XNOR] = ~(a[LANE_XNOR] ^ b[LANE_XNOR]);
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller for the 4-lane gate block: sweeps 256 operand vectors, checks Y
// against the golden model and reports pass/fail, mismatch count and first failure.
// Optional feature macro: GATE_BIST_STOP_ON_FAIL_EN -- when defined the sweep ends at
// the first mismatching vector; otherwise all 256 vectors always run.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       a_o,
    output logic [7:0]       b_o,
    input  logic [7:0]       y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_fail_vec,
    output logic             first_fail_vld
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]    ERR_MAX     = ERR_W'(NUM_VECTORS);

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_cnt;
    logic [SETTLE_W-1:0] r_settle;
    logic [7:0]          r_a;
    logic [7:0]          r_b;
    logic [ERR_W-1:0]    r_err;
    logic [7:0]          r_ff_vec;
    logic                r_ff_vld;

    logic [7:0] w_exp;
    logic [7:0] w_cnt_nxt;
    logic       w_start_acc;
    logic       w_mismatch;
    logic       w_last_vec;
    logic       w_stop_hit;

    gate_bist_expect u_expect (
        .a   (r_a),
        .b   (r_b),
        .exp (w_exp)
    );

    assign w_cnt_nxt   = r_cnt + 8'd1;
    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch  = (r_state == SAMPLE) && (y_i != w_exp);
    assign w_last_vec  = (r_cnt == 8'hFF);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign w_stop_hit = w_mismatch;
`else
    assign w_stop_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic: settle in DRIVE, one-cycle SAMPLE, loop until last vector
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = DRIVE;
            DRIVE:   if (r_settle == '0) w_next_state = SAMPLE;
            SAMPLE:  if (w_last_vec || w_stop_hit) w_next_state = DONE;
                     else w_next_state = DRIVE;
            DONE:    if (start) w_next_state = DRIVE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = (r_state == DRIVE) || (r_state == SAMPLE);
        done = (r_state == DONE);
        pass = (r_state == DONE) && (r_err == '0);
    end

    // Vector counter, settle timer, registered operands and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 8'h00;
            r_settle <= '0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_err    <= '0;
            r_ff_vec <= 8'h00;
            r_ff_vld <= 1'b0;
        end else if (w_start_acc) begin
            r_cnt    <= 8'h00;
            r_settle <= SETTLE_LOAD;
            r_a      <= vec_a(8'h00);
            r_b      <= vec_b(8'h00);
            r_err    <= '0;
            r_ff_vec <= 8'h00;
            r_ff_vld <= 1'b0;
        end else begin
            case (r_state)
                DRIVE: begin
                    if (r_settle != '0) r_settle <= r_settle - 1'b1;
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                        if (!r_ff_vld) begin
                            r_ff_vec <= r_cnt;
                            r_ff_vld <= 1'b1;
                        end
                    end
                    // Advance only when another vector follows; DONE keeps the last one
                    if (w_next_state == DRIVE) begin
                        r_cnt    <= w_cnt_nxt;
                        r_settle <= SETTLE_LOAD;
                        r_a      <= vec_a(w_cnt_nxt);
                        r_b      <= vec_b(w_cnt_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_o            = r_a;
    assign b_o            = r_b;
    assign err_count      = r_err;
    assign first_fail_vec = r_ff_vec;
    assign first_fail_vld = r_ff_vld;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl with a fault-injectable gate-block model.
// Honours GATE_BIST_STOP_ON_FAIL_EN when computing expected sweep results.
`timescale 1ns/1ps
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a_o, b_o, y_i;
    logic       busy, done, pass;
    logic [8:0] err_count;
    logic [7:0] first_fail_vec;
    logic       first_fail_vld;

    gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .a_o            (a_o),
        .b_o            (b_o),
        .y_i            (y_i),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fault_mode = 0;
    int edge_no = 0;
    int accept_edge = 0;

    typedef struct {
        int         cycles;
        logic [8:0] err;
        logic [7:0] ffv;
        logic       vld;
        logic       pass;
        logic [7:0] last_a;
        logic [7:0] last_b;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) edge_no <= edge_no + 1;

    // Fault-free gate block, derived from the vector index (a low nibble = v[3:0], b = v[7:4])
    function automatic logic [7:0] gold(input logic [7:0] v);
        logic [7:0] g;
        g    = 8'h00;
        g[0] = v[0] & v[4];
        g[1] = ~(v[1] & v[5]);
        g[2] = v[2] ^ v[6];
        g[3] = ~(v[3] ^ v[7]);
        return g;
    endfunction

    // Gate block with injected faults; samp=1 marks the cycle the controller should sample
    function automatic logic [7:0] faulty(input int mode, input logic [7:0] v, input bit samp);
        logic [7:0] g;
        g = gold(v);
        case (mode)
            1: g = g & 8'hFD;
            2: g = g | 8'h80;
            3: if (v == 8'h37) g = g ^ 8'h04;
            4: g = g | 8'h01;
            5: if (!samp) g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    always @* y_i = faulty(fault_mode, {b_o[3:0], a_o[3:0]}, ((edge_no - accept_edge) % 2) == 1);

    // Expected outcome of a full sweep under a given fault
    function automatic exp_t model(input int mode);
        exp_t e;
        logic [7:0] vv;
        e.cycles = 0; e.err = '0; e.ffv = 8'h00; e.vld = 1'b0;
        e.last_a = 8'h00; e.last_b = 8'h00;
        for (int v = 0; v < 256; v++) begin
            vv = 8'(v);
            e.cycles += 2;
            e.last_a = {~vv[3:0], vv[3:0]};
            e.last_b = {~vv[7:4], vv[7:4]};
            if (faulty(mode, vv, 1'b1) !== gold(vv)) begin
                e.err = e.err + 9'd1;
                if (!e.vld) begin
                    e.ffv = vv;
                    e.vld = 1'b1;
                end
                if (STOP_ON_FAIL) break;
            end
        end
        e.pass = (e.err == 9'd0);
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        accept_edge = edge_no;
    endtask

    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_vld} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_values: got a=%h b=%h busy=%b done=%b pass=%b err=%0d ffv=%h vld=%b, want all 0",
                     a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_vld);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || a_o !== 8'h00) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b done=%b a=%h, want 0 0 00", busy, done, a_o);
        end
    endtask

    task automatic test_sweeps();
        int    modes[6] = '{0, 1, 2, 3, 5, 4};
        string names[6] = '{"clean", "y1_sa0", "y7_sa1", "y2_flip37", "drive_glitch", "y0_sa1"};
        exp_t  e;
        int    cyc;
        for (int i = 0; i < 6; i++) begin
            fault_mode = modes[i];
            sb.push_back(model(modes[i]));
            pulse_start();
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || a_o !== 8'hF0 || b_o !== 8'hF0) begin
                n_err++;
                $display("FAIL %s first_vector: got busy=%b done=%b a=%h b=%h, want 1 0 f0 f0",
                         names[i], busy, done, a_o, b_o);
            end
            wait_done(0, cyc);
            e = sb.pop_front();
            n_vec++;
            if (cyc != e.cycles) begin
                n_err++;
                $display("FAIL %s done_latency: got %0d cycles, want %0d", names[i], cyc, e.cycles);
            end
            n_vec++;
            if (err_count !== e.err) begin
                n_err++;
                $display("FAIL %s err_count: got %0d, want %0d", names[i], err_count, e.err);
            end
            n_vec++;
            if (first_fail_vld !== e.vld || first_fail_vec !== e.ffv) begin
                n_err++;
                $display("FAIL %s first_fail: got vld=%b vec=%h, want vld=%b vec=%h",
                         names[i], first_fail_vld, first_fail_vec, e.vld, e.ffv);
            end
            n_vec++;
            if (pass !== e.pass || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s pass_busy: got pass=%b busy=%b, want pass=%b busy=0",
                         names[i], pass, busy, e.pass);
            end
            n_vec++;
            if (a_o !== e.last_a || b_o !== e.last_b) begin
                n_err++;
                $display("FAIL %s last_vector: got a=%h b=%h, want a=%h b=%h",
                         names[i], a_o, b_o, e.last_a, e.last_b);
            end
            repeat (4) @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b1 || err_count !== e.err || a_o !== e.last_a) begin
                n_err++;
                $display("FAIL %s done_hold: got done=%b err=%0d a=%h, want 1 %0d %h",
                         names[i], done, err_count, a_o, e.err, e.last_a);
            end
        end
    endtask

    task automatic test_restart_clears();
        exp_t e;
        int   cyc;
        fault_mode = 0;
        sb.push_back(model(0));
        pulse_start();
        n_vec++;
        if (err_count !== 9'd0 || first_fail_vld !== 1'b0 || first_fail_vec !== 8'h00 ||
            done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_clear: got err=%0d vld=%b ffv=%h done=%b busy=%b, want 0 0 00 0 1",
                     err_count, first_fail_vld, first_fail_vec, done, busy);
        end
        wait_done(0, cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != e.cycles || pass !== e.pass || err_count !== e.err) begin
            n_err++;
            $display("FAIL restart_sweep: got cyc=%0d pass=%b err=%0d, want %0d %b %0d",
                     cyc, pass, err_count, e.cycles, e.pass, e.err);
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   cyc;
        fault_mode = 0;
        sb.push_back(model(0));
        pulse_start();
        cyc = 0;
        repeat (49) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || err_count !== 9'd0) begin
            n_err++;
            $display("FAIL busy_start_state: got busy=%b err=%0d, want 1 0", busy, err_count);
        end
        wait_done(cyc, cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != e.cycles || pass !== e.pass) begin
            n_err++;
            $display("FAIL busy_start_ignored: got cyc=%0d pass=%b, want %0d %b", cyc, pass, e.cycles, e.pass);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        int   guard;
        fault_mode = 1;
        pulse_start();
        guard = 0;
        while (!({b_o[3:0], a_o[3:0]} == 8'd100 && busy === 1'b1) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (guard >= 1000) begin
            n_err++;
            $display("FAIL reach_vector_100: got timeout after %0d cycles, want vector 100", guard);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_vld} !== 37'd0) begin
            n_err++;
            $display("FAIL async_reset: got a=%h b=%h busy=%b done=%b err=%0d ffv=%h vld=%b, want all 0",
                     a_o, b_o, busy, done, err_count, first_fail_vec, first_fail_vld);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || a_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_beats_start: got busy=%b a=%h, want 0 00", busy, a_o);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 9'd0) begin
            n_err++;
            $display("FAIL idle_after_mid_reset: got busy=%b done=%b err=%0d, want 0 0 0", busy, done, err_count);
        end
        fault_mode = 0;
        sb.push_back(model(0));
        pulse_start();
        wait_done(0, cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != e.cycles || pass !== 1'b1 || err_count !== 9'd0) begin
            n_err++;
            $display("FAIL restart_after_reset: got cyc=%0d pass=%b err=%0d, want %0d 1 0",
                     cyc, pass, err_count, e.cycles);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_sweeps();
        test_restart_clears();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
